smith_waterman_pe_array: RTL and testbench

Linear systolic array of NUM_PE processing elements that computes the local-alignment (Smith-Waterman, linear gap) best score between a query of NUM_PE characters and a streamed database sequence. It sits directly downstream of the cache-line-to-byte database FIFO. Each cycle it dequeues at most one 8-bit character from that FIFO's show-ahead output and reports the best score and its end coordinates once the stream has drained.

---
 rtl/smith_waterman_pkg.sv | 20 ++
 rtl/smith_waterman_pe_array_if.sv | 31 +++
 rtl/smith_waterman_pe.sv | 79 +++++++
 rtl/smith_waterman_pe_array.sv | 139 +++++++++++++
 tb/tb_smith_waterman_pe_array.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/smith_waterman_pkg.sv
// Shared types and default scoring constants for the Smith-Waterman PE array.
// Holds no logic, so it adds no latency and has no flow control of its own.
package smith_waterman_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STREAM,
    DRAIN,
    REDUCE,
    DONE
  } sw_array_state_t;

  localparam int SW_CHAR_WIDTH       = 8;
  localparam int SW_SCORE_WIDTH      = 16;
  localparam int SW_MATCH_SCORE      = 2;
  localparam int SW_MISMATCH_PENALTY = 1;
  localparam int SW_GAP_PENALTY      = 1;

endpackage

// File: rtl/smith_waterman_pe_array_if.sv
// Job control, FIFO pop port and result bus of the Smith-Waterman PE array.
// The slave pops the FIFO's show-ahead head on fifo_deq and never stalls it.
interface smith_waterman_pe_array_if #(
  parameter int NUM_PE      = 8,
  parameter int SCORE_WIDTH = 16
);
  localparam int QPOS_WIDTH = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  logic                    start;
  logic [8*NUM_PE-1:0]     query_data;
  logic [31:0]             db_length;
  logic [7:0]              fifo_data;
  logic                    fifo_not_empty;
  logic                    fifo_deq;
  logic                    busy;
  logic                    done;
  logic [SCORE_WIDTH-1:0]  max_score;
  logic [QPOS_WIDTH-1:0]   max_qpos;
  logic [31:0]             max_pos;

  modport master (
    output start, query_data, db_length, fifo_data, fifo_not_empty,
    input  fifo_deq, busy, done, max_score, max_qpos, max_pos
  );

  modport slave (
    input  start, query_data, db_length, fifo_data, fifo_not_empty,
    output fifo_deq, busy, done, max_score, max_qpos, max_pos
  );

endinterface

// File: rtl/smith_waterman_pe.sv
// One systolic cell: scores H(i,j) on a valid input, forwards char/valid/H one cycle later.
// Latency 1 cycle per cell; bubbles pass straight through and never stall the array.
module smith_waterman_pe
  import smith_waterman_pkg::*;
#(
  parameter int SCORE_WIDTH      = SW_SCORE_WIDTH,
  parameter int MATCH_SCORE      = SW_MATCH_SCORE,
  parameter int MISMATCH_PENALTY = SW_MISMATCH_PENALTY,
  parameter int GAP_PENALTY      = SW_GAP_PENALTY
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic [7:0]             q,
  input  logic                   in_vld,
  input  logic [7:0]             in_chr,
  input  logic [SCORE_WIDTH-1:0] in_h,
  output logic                   out_vld,
  output logic [7:0]             out_chr,
  output logic [SCORE_WIDTH-1:0] out_h,
  output logic [SCORE_WIDTH-1:0] best_score,
  output logic [31:0]            best_pos
);
  localparam int AW = SCORE_WIDTH + 2;
  typedef logic signed [AW-1:0] acc_t;
  localparam acc_t SAT = acc_t'({2'b00, {SCORE_WIDTH{1'b1}}});

  logic [SCORE_WIDTH-1:0] diag;
  logic [31:0]            col;
  acc_t                   t_diag, t_up, t_left, t_max;
  logic [SCORE_WIDTH-1:0] h_new;

  // out_h doubles as the left neighbour: it is this cell's previous H.
  always_comb begin
    t_diag = $signed({2'b00, diag}) +
             ((in_chr == q) ? acc_t'(MATCH_SCORE) : -acc_t'(MISMATCH_PENALTY));
    t_up   = $signed({2'b00, in_h})  - acc_t'(GAP_PENALTY);
    t_left = $signed({2'b00, out_h}) - acc_t'(GAP_PENALTY);
    t_max  = '0;
    if (t_diag > t_max) t_max = t_diag;
    if (t_up   > t_max) t_max = t_up;
    if (t_left > t_max) t_max = t_left;
    h_new = (t_max > SAT) ? {SCORE_WIDTH{1'b1}} : t_max[SCORE_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_vld    <= 1'b0;
      out_chr    <= '0;
      out_h      <= '0;
      diag       <= '0;
      col        <= '0;
      best_score <= '0;
      best_pos   <= '0;
    end else if (clear) begin
      out_vld    <= 1'b0;
      out_chr    <= '0;
      out_h      <= '0;
      diag       <= '0;
      col        <= '0;
      best_score <= '0;
      best_pos   <= '0;
    end else begin
      out_vld <= in_vld;
      out_chr <= in_chr;
      if (in_vld) begin
        out_h <= h_new;
        diag  <= in_h;
        col   <= col + 32'd1;
        // Strictly greater keeps the earliest column on ties.
        if (h_new > best_score) begin
          best_score <= h_new;
          best_pos   <= col;
        end
      end
    end
  end

endmodule

// File: rtl/smith_waterman_pe_array.sv
// Streams db chars through NUM_PE cells and reports the best local-alignment score and position.
// Pops at most one char per cycle when the FIFO is non-empty; done = last deq + NUM_PE + 2 cycles.
module smith_waterman_pe_array
  import smith_waterman_pkg::*;
#(
  parameter int NUM_PE           = 8,
  parameter int SCORE_WIDTH      = SW_SCORE_WIDTH,
  parameter int MATCH_SCORE      = SW_MATCH_SCORE,
  parameter int MISMATCH_PENALTY = SW_MISMATCH_PENALTY,
  parameter int GAP_PENALTY      = SW_GAP_PENALTY
) (
  input logic                clk,
  input logic                reset_n,
  smith_waterman_pe_array_if.slave bus
);
  localparam int QW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int CW = $clog2(NUM_PE + 1);

  sw_array_state_t state, state_nxt;
  logic [8*NUM_PE-1:0] query;
  logic [31:0]         db_len, consumed;
  logic [CW-1:0]       drain_cnt;
  logic                clear, deq;

  logic [NUM_PE:0]                  vld;
  logic [NUM_PE:0][7:0]             chr;
  logic [NUM_PE:0][SCORE_WIDTH-1:0] h;
  logic [NUM_PE-1:0][SCORE_WIDTH-1:0] best_score;
  logic [NUM_PE-1:0][31:0]            best_pos;

  logic [SCORE_WIDTH-1:0] red_score, max_score;
  logic [QW-1:0]          red_qpos, max_qpos;
  logic [31:0]            red_pos, max_pos;
  logic                   unused_tail;

  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    deq       = 1'b0;
    case (state)
      IDLE:   if (bus.start) begin
                clear     = 1'b1;
                state_nxt = LOAD;
              end
      LOAD:   state_nxt = (db_len == 32'd0) ? DRAIN : STREAM;
      STREAM: begin
                deq = bus.fifo_not_empty && (consumed < db_len);
                if (deq && (consumed + 32'd1 == db_len)) state_nxt = DRAIN;
              end
      DRAIN:  if (drain_cnt == '0) state_nxt = REDUCE;
      REDUCE: state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      query     <= '0;
      db_len    <= '0;
      consumed  <= '0;
      drain_cnt <= '0;
      max_score <= '0;
      max_qpos  <= '0;
      max_pos   <= '0;
    end else begin
      state <= state_nxt;
      if (clear) begin
        query     <= bus.query_data;
        db_len    <= bus.db_length;
        consumed  <= '0;
        max_score <= '0;
        max_qpos  <= '0;
        max_pos   <= '0;
      end
      if (deq) consumed <= consumed + 32'd1;
      // The last char needs NUM_PE more edges to reach the final cell.
      if (state_nxt == DRAIN && state != DRAIN) drain_cnt <= CW'(NUM_PE - 1);
      else if (state == DRAIN)                  drain_cnt <= drain_cnt - 1'b1;
      if (state == REDUCE) begin
        max_score <= red_score;
        max_qpos  <= red_qpos;
        max_pos   <= red_pos;
      end
    end
  end

  assign vld[0] = deq;
  assign chr[0] = bus.fifo_data;
  assign h[0]   = '0;

  for (genvar g = 0; g < NUM_PE; g++) begin : g_pe
    smith_waterman_pe #(
      .SCORE_WIDTH      (SCORE_WIDTH),
      .MATCH_SCORE      (MATCH_SCORE),
      .MISMATCH_PENALTY (MISMATCH_PENALTY),
      .GAP_PENALTY      (GAP_PENALTY)
    ) u_pe (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (clear),
      .q          (query[8*g +: 8]),
      .in_vld     (vld[g]),
      .in_chr     (chr[g]),
      .in_h       (h[g]),
      .out_vld    (vld[g+1]),
      .out_chr    (chr[g+1]),
      .out_h      (h[g+1]),
      .best_score (best_score[g]),
      .best_pos   (best_pos[g])
    );
  end

  // The last cell's forwarded outputs have no consumer.
  assign unused_tail = ^{vld[NUM_PE], chr[NUM_PE], h[NUM_PE]};

  // Strict compare in ascending order lets the lowest cell index win ties.
  always_comb begin
    red_score = '0;
    red_qpos  = '0;
    red_pos   = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (best_score[i] > red_score) begin
        red_score = best_score[i];
        red_qpos  = QW'(i);
        red_pos   = best_pos[i];
      end
    end
  end

  assign bus.fifo_deq  = deq;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = (state == DONE);
  assign bus.max_score = max_score;
  assign bus.max_qpos  = max_qpos;
  assign bus.max_pos   = max_pos;

endmodule

// File: tb/tb_smith_waterman_pe_array.sv
// Self-checking bench: directed and random jobs against a full-matrix Smith-Waterman model,
// with per-cycle checks of fifo_deq and done timing.
module tb_smith_waterman_pe_array;
  localparam int NUM_PE = 8;
  localparam int MAXL   = 32;
  localparam int MAXC   = 256;
  localparam int MATCH  = 2;
  localparam int MISM   = 1;
  localparam int GAP    = 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  smith_waterman_pe_array_if #(.NUM_PE(NUM_PE), .SCORE_WIDTH(16)) bus ();

  smith_waterman_pe_array #(.NUM_PE(NUM_PE)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int vectors = 0;
  int fails   = 0;
  logic [7:0] db [MAXL];
  bit ne_pat [MAXC];
  int hm [NUM_PE][MAXL];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack_query(input string s);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < NUM_PE; i++) r[8*i +: 8] = s[i];
    return r;
  endfunction

  task automatic set_db(input string s);
    for (int i = 0; i < s.len(); i++) db[i] = s[i];
  endtask

  function automatic logic [7:0] rand_base();
    logic [31:0] alph;
    alph = "ACGT";
    return alph[8*$urandom_range(0, 3) +: 8];
  endfunction

  // Full DP matrix; best = global max, ties to lowest query index then lowest db index.
  task automatic model(input logic [63:0] qry, input int len,
                       output int bs, output int bq, output int bp);
    int d, u, l, s, v;
    bs = 0; bq = 0; bp = 0;
    for (int i = 0; i < NUM_PE; i++) begin
      for (int j = 0; j < len; j++) begin
        d = (i == 0 || j == 0) ? 0 : hm[i-1][j-1];
        u = (i == 0) ? 0 : hm[i-1][j];
        l = (j == 0) ? 0 : hm[i][j-1];
        s = (qry[8*i +: 8] == db[j]) ? MATCH : -MISM;
        v = 0;
        if (d + s > v) v = d + s;
        if (u - GAP > v) v = u - GAP;
        if (l - GAP > v) v = l - GAP;
        hm[i][j] = v;
      end
    end
    for (int i = 0; i < NUM_PE; i++)
      for (int j = 0; j < len; j++)
        if (hm[i][j] > bs) begin bs = hm[i][j]; bq = i; bp = j; end
  endtask

  // mode 0: FIFO always non-empty, 1: non-empty on even cycles, 2: random.
  // abort_at > 0 returns right after that cycle's checks (mid-job).
  task automatic run_job(input string tag, input logic [63:0] qry, input int len,
                         input int mode, input int abort_at);
    int k, idx, cnt, c_last, exp_done, dut_deqs, es, eq, ep;
    bit exp_deq;
    for (int c = 0; c < MAXC; c++) begin
      case (mode)
        0: ne_pat[c] = 1'b1;
        1: ne_pat[c] = (c % 2 == 0);
        default: ne_pat[c] = (c >= 100) || ($urandom_range(0, 3) != 0);
      endcase
    end
    c_last = 1;
    cnt = 0;
    for (int c = 2; c < MAXC && cnt < len; c++)
      if (ne_pat[c]) begin cnt++; c_last = c; end
    exp_done = c_last + NUM_PE + 2;
    model(qry, len, es, eq, ep);

    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.query_data = qry;
    bus.db_length  = len;
    @(posedge clk); #1;
    bus.start      = 1'b0;
    bus.query_data = {2{$urandom()}};
    bus.db_length  = $urandom_range(0, 50);
    idx = 0;
    dut_deqs = 0;
    for (k = 1; k <= exp_done + 1; k++) begin
      bus.fifo_not_empty = ne_pat[k];
      bus.fifo_data      = (ne_pat[k] && idx < len) ? db[idx] : 8'($urandom());
      @(negedge clk);
      exp_deq = (k >= 2) && ne_pat[k] && (idx < len);
      check({tag, " fifo_deq"}, bus.fifo_deq, exp_deq);
      check({tag, " done"}, bus.done, (k == exp_done));
      if (bus.fifo_deq === 1'b1) dut_deqs++;
      if (exp_deq) idx++;
      if (k == exp_done) begin
        check({tag, " max_score"}, bus.max_score, es);
        check({tag, " max_qpos"}, bus.max_qpos, eq);
        check({tag, " max_pos"}, bus.max_pos, ep);
        check({tag, " deq count"}, dut_deqs, len);
      end
      if (k == exp_done + 1) check({tag, " busy after done"}, bus.busy, 0);
      if (k == abort_at) return;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int s, q, p, len;
    logic [63:0] qry;
    string qs;
    bus.start = 1'b0;
    bus.query_data = '0;
    bus.db_length = '0;
    bus.fifo_data = '0;
    bus.fifo_not_empty = 1'b0;
    #3;
    check("reset fifo_deq", bus.fifo_deq, 0);
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset max_score", bus.max_score, 0);
    check("reset max_qpos", bus.max_qpos, 0);
    check("reset max_pos", bus.max_pos, 0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    // Exact match on the diagonal.
    set_db("ACGTACGT");
    model(pack_query("ACGTACGT"), 8, s, q, p);
    check("model exact score", s, 16);
    check("model exact qpos", q, 7);
    check("model exact pos", p, 7);
    run_job("exact", pack_query("ACGTACGT"), 8, 0, 0);

    // One deletion in the database.
    set_db("ACGACGT");
    model(pack_query("ACGTACGT"), 7, s, q, p);
    check("model gap score", s, 13);
    check("model gap qpos", q, 7);
    check("model gap pos", p, 6);
    run_job("gap", pack_query("ACGTACGT"), 7, 0, 0);

    // No matches at all.
    set_db("CCCC");
    model(pack_query("AAAAAAAA"), 4, s, q, p);
    check("model nomatch score", s, 0);
    run_job("nomatch", pack_query("AAAAAAAA"), 4, 0, 0);

    // Same as the first job with the FIFO running half empty.
    set_db("ACGTACGT");
    run_job("toggle", pack_query("ACGTACGT"), 8, 1, 0);

    // Empty database.
    run_job("empty", pack_query("ACGTACGT"), 0, 0, 0);

    // Reset in the middle of streaming, then a clean job.
    run_job("abort", pack_query("ACGTACGT"), 8, 0, 5);
    reset_n = 1'b0;
    #1;
    check("midreset fifo_deq", bus.fifo_deq, 0);
    check("midreset busy", bus.busy, 0);
    check("midreset done", bus.done, 0);
    check("midreset max_score", bus.max_score, 0);
    check("midreset max_qpos", bus.max_qpos, 0);
    check("midreset max_pos", bus.max_pos, 0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    run_job("after reset", pack_query("ACGTACGT"), 8, 0, 0);

    // Random queries and databases with a random FIFO fill pattern.
    for (int t = 0; t < 12; t++) begin
      qry = '0;
      for (int i = 0; i < NUM_PE; i++) qry[8*i +: 8] = rand_base();
      len = $urandom_range(0, 24);
      for (int j = 0; j < len; j++) db[j] = rand_base();
      // Occasionally plant the query in the database to reach high scores.
      if (t % 3 == 0 && len >= NUM_PE + 2)
        for (int i = 0; i < NUM_PE; i++) db[2 + i] = qry[8*i +: 8];
      run_job($sformatf("rand%0d", t), qry, len, (t % 2 == 0) ? 2 : 1, 0);
    end

    qs = "";
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
